// File: rtl/lut_access_sched.sv
// Arbitrates one lookup-table operation per cycle between NREQ lookup engines (round-robin) and the host.
// Optional LUT_INIT_CLEAR_EN: after reset, walks the table writing zero before granting anything.
`ifndef PORT_NUM
`define PORT_NUM 4
`endif

module lut_access_sched #(
  parameter int NREQ     = 4,
  parameter int AW       = 8,
  parameter int DW       = `PORT_NUM + 28,
  parameter int HOST_MAX = 4,
  localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int SW      = $clog2(HOST_MAX + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*24-1:0]   req_addr,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [DW-1:0]        rsp_data,
  output logic                 rsp_oor,
  input  logic                 host_wr,
  input  logic                 host_rd,
  input  logic [23:0]          host_addr,
  input  logic [DW-1:0]        host_wdata,
  output logic                 host_ack,
  output logic [DW-1:0]        host_rdata,
  output logic                 init_done,
  output logic                 tbl_host_wren,
  output logic [23:0]          tbl_host_addr,
  output logic [DW-1:0]        tbl_host_wdata,
  input  logic [DW-1:0]        tbl_host_rdata,
  output logic                 tbl_fwd_rden,
  output logic [23:0]          tbl_fwd_addr,
  input  logic [DW-1:0]        tbl_fwd_rdata
);

  logic           init_wr;
  logic [AW-1:0]  init_addr;

`ifdef LUT_INIT_CLEAR_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  state_t         state_q;
  logic [AW-1:0]  init_addr_q;
  logic           init_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_addr_q <= init_addr_q + 1'b1;
          if (init_addr_q == '1) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign init_done = init_done_q;
  assign init_wr   = rst_n & (state_q == ST_INIT);
  assign init_addr = init_addr_q;
`else
  assign init_done = 1'b1;
  assign init_wr   = 1'b0;
  assign init_addr = '0;
`endif

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [SW-1:0]  streak_q, streak_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [DW-1:0]  rsp_data_q, rsp_data_d;
  logic           rsp_oor_q, rsp_oor_d;
  logic           host_ack_q, host_ack_d;
  logic [DW-1:0]  host_rdata_q, host_rdata_d;

  logic           run, lk_pend, host_pend, host_oor, lk_oor;
  logic           host_slot, lk_slot, gnt_vld;
  logic [IDW-1:0] gnt_idx, cand;
  logic [23:0]    lk_addr;

  // Outputs that face the table and the requesters are forced quiet while reset is held.
  assign run       = init_done & rst_n;
  assign lk_pend   = |req_valid;
  assign host_pend = (host_wr | host_rd) & ~host_ack_q;
  assign host_oor  = |host_addr[23:AW];
  assign host_slot = run & host_pend & (~lk_pend | (streak_q < SW'(HOST_MAX)));
  assign lk_slot   = run & ~host_slot & gnt_vld;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr_q;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % NREQ);
      if (!gnt_vld && req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign lk_addr = req_addr[24*gnt_idx +: 24];
  assign lk_oor  = |lk_addr[23:AW];

  always_comb begin
    req_ready = '0;
    if (lk_slot) req_ready[gnt_idx] = 1'b1;
  end

  assign tbl_fwd_rden   = lk_slot & ~lk_oor;
  assign tbl_fwd_addr   = lk_addr;
  assign tbl_host_wren  = init_wr | (host_slot & host_wr & ~host_oor);
  assign tbl_host_addr  = init_wr ? 24'(init_addr) : host_addr;
  assign tbl_host_wdata = (host_slot & host_wr) ? host_wdata : '0;

  always_comb begin
    ptr_d        = lk_slot ? gnt_idx : ptr_q;
    streak_d     = streak_q;
    if (host_slot && lk_pend)
      streak_d = streak_q + 1'b1;
    else if (lk_slot || !lk_pend)
      streak_d = '0;
    rsp_valid_d  = lk_slot;
    rsp_id_d     = lk_slot ? gnt_idx : rsp_id_q;
    rsp_oor_d    = lk_slot ? lk_oor : rsp_oor_q;
    rsp_data_d   = rsp_data_q;
    if (lk_slot) rsp_data_d = lk_oor ? '0 : tbl_fwd_rdata;
    host_ack_d   = host_slot;
    host_rdata_d = host_rdata_q;
    if (host_slot && !host_wr) host_rdata_d = host_oor ? '0 : tbl_host_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= IDW'(NREQ - 1);
      streak_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      rsp_oor_q    <= 1'b0;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      streak_q     <= streak_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_oor_q    <= rsp_oor_d;
      host_ack_q   <= host_ack_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_oor    = rsp_oor_q;
  assign host_ack   = host_ack_q;
  assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_lut_access_sched.sv
// Directed bench for lut_access_sched with a behavioural 256-entry table behind both ports.
module tb_lut_access_sched;
  localparam int NREQ = 4;
  localparam int AW   = 8;
  localparam int DW   = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ*24-1:0] req_addr;
  logic [NREQ-1:0]  req_ready;
  logic             rsp_valid;
  logic [1:0]       rsp_id;
  logic [DW-1:0]    rsp_data;
  logic             rsp_oor;
  logic             host_wr, host_rd;
  logic [23:0]      host_addr;
  logic [DW-1:0]    host_wdata;
  logic             host_ack;
  logic [DW-1:0]    host_rdata;
  logic             init_done;
  logic             tbl_host_wren;
  logic [23:0]      tbl_host_addr;
  logic [DW-1:0]    tbl_host_wdata;
  logic [DW-1:0]    tbl_host_rdata;
  logic             tbl_fwd_rden;
  logic [23:0]      tbl_fwd_addr;
  logic [DW-1:0]    tbl_fwd_rdata;

  logic [DW-1:0]    mem [256];
  logic             preload;
  int               check_cnt = 0;
  int               error_cnt = 0;

  always #5 clk = ~clk;

  lut_access_sched #(.NREQ(NREQ), .AW(AW), .DW(DW), .HOST_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_oor(rsp_oor),
    .host_wr(host_wr), .host_rd(host_rd), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .init_done(init_done),
    .tbl_host_wren(tbl_host_wren), .tbl_host_addr(tbl_host_addr),
    .tbl_host_wdata(tbl_host_wdata), .tbl_host_rdata(tbl_host_rdata),
    .tbl_fwd_rden(tbl_fwd_rden), .tbl_fwd_addr(tbl_fwd_addr), .tbl_fwd_rdata(tbl_fwd_rdata)
  );

  // Table model: preload pattern is 0x1000 + address.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h1000 + i;
    end else if (tbl_host_wren) begin
      mem[tbl_host_addr[7:0]] <= tbl_host_wdata;
    end
  end
  assign tbl_host_rdata = mem[tbl_host_addr[7:0]];
  assign tbl_fwd_rdata  = mem[tbl_fwd_addr[7:0]];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_cnt++;
    if (got !== exp) begin
      error_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_addr(input int i, input logic [23:0] a);
    req_addr[24*i +: 24] = a;
  endtask

  logic [3:0] rr_rdy [3] = '{4'b1000, 4'b0010, 4'b1000};
  logic [1:0] rr_id  [3] = '{2'd3, 2'd1, 2'd3};
  logic [31:0] rr_dat [3] = '{32'h1009, 32'h1007, 32'h1009};

  initial begin
    int bad;
    rst_n = 1'b0; preload = 1'b1;
    req_valid = '0; req_addr = '0;
    host_wr = 1'b0; host_rd = 1'b0; host_addr = '0; host_wdata = '0;
    @(negedge clk);
    preload = 1'b0;

    // Reset values, with requests asserted during reset.
    req_valid = 4'hF; host_rd = 1'b1; host_wr = 1'b1; host_wdata = 32'hFFFF;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_id", 64'(rsp_id), 64'(0));
    check("rst_rsp_data", 64'(rsp_data), 64'(0));
    check("rst_rsp_oor", 64'(rsp_oor), 64'(0));
    check("rst_host_ack", 64'(host_ack), 64'(0));
    check("rst_host_rdata", 64'(host_rdata), 64'(0));
    check("rst_tbl_wren", 64'(tbl_host_wren), 64'(0));
    check("rst_tbl_rden", 64'(tbl_fwd_rden), 64'(0));
    check("rst_tbl_wdata", 64'(tbl_host_wdata), 64'(0));
`ifdef LUT_INIT_CLEAR_EN
    check("rst_init_done", 64'(init_done), 64'(0));
`else
    check("rst_init_done", 64'(init_done), 64'(1));
`endif
    req_valid = '0; host_rd = 1'b0; host_wr = 1'b0; host_wdata = '0;
    tick();
    rst_n = 1'b1;

`ifdef LUT_INIT_CLEAR_EN
    // Clear walk: no grants for 256 cycles, then lookups see zero.
    req_valid = 4'b1000; set_addr(3, 24'h20);
    bad = 0;
    repeat (256) begin
      #1;
      if (init_done !== 1'b0 || req_ready !== 4'b0) bad++;
      tick();
    end
    check("init_hold", 64'(bad), 64'(0));
    #1;
    check("init_done_set", 64'(init_done), 64'(1));
    check("init_rdy", 64'(req_ready), 64'(4'b1000));
    tick();
    check("init_clear_data", 64'(rsp_data), 64'(0));
    req_valid = '0; preload = 1'b1;
    tick();
    preload = 1'b0;
`endif

    // Round-robin with all four requesters held.
    for (int i = 0; i < 4; i++) set_addr(i, 24'(i + 1));
    req_valid = 4'hF;
    for (int k = 0; k < 7; k++) begin
      #1;
      check("rr_ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      tick();
      check("rr_rsp_valid", 64'(rsp_valid), 64'(1));
      check("rr_rsp_id", 64'(rsp_id), 64'(k % 4));
      check("rr_rsp_data", 64'(rsp_data), 64'(32'h1001 + (k % 4)));
    end
    req_valid = '0;

    // Host read held with req0 held: host, lookup, host, lookup ...
    host_rd = 1'b1; host_addr = 24'h10;
    req_valid = 4'b0001; set_addr(0, 24'h20);
    for (int k = 0; k < 6; k++) begin
      #1;
      check("hp_ready", 64'(req_ready), 64'((k % 2 == 0) ? 4'b0000 : 4'b0001));
      tick();
      check("hp_ack", 64'(host_ack), 64'(k % 2 == 0));
      check("hp_rsp_valid", 64'(rsp_valid), 64'(k % 2 == 1));
      if (k % 2 == 0) check("hp_rdata", 64'(host_rdata), 64'(32'h1010));
      else            check("hp_rsp_data", 64'(rsp_data), 64'(32'h1020));
    end
    host_rd = 1'b0; req_valid = '0;

    // Host write then lookup of the same address.
    host_wr = 1'b1; host_addr = 24'h05; host_wdata = 32'hABC;
    req_valid = 4'b0010; set_addr(1, 24'h05);
    #1;
    check("wr_no_grant", 64'(req_ready), 64'(0));
    check("wr_wren", 64'(tbl_host_wren), 64'(1));
    check("wr_no_rden", 64'(tbl_fwd_rden), 64'(0));
    tick();
    check("wr_ack", 64'(host_ack), 64'(1));
    check("wr_rdata_held", 64'(host_rdata), 64'(32'h1010));
    #1;
    check("wr_ack_grant", 64'(req_ready), 64'(4'b0010));
    check("wr_no_reserve", 64'(tbl_host_wren), 64'(0));
    host_wr = 1'b0;
    tick();
    check("wr_rsp_valid", 64'(rsp_valid), 64'(1));
    check("wr_rsp_id", 64'(rsp_id), 64'(1));
    check("wr_rsp_data", 64'(rsp_data), 64'(32'hABC));
    check("wr_ack_once", 64'(host_ack), 64'(0));
    req_valid = '0;

    // Out-of-range lookup and host accesses.
    req_valid = 4'b0100; set_addr(2, 24'h000100);
    #1;
    check("oor_ready", 64'(req_ready), 64'(4'b0100));
    check("oor_no_rden", 64'(tbl_fwd_rden), 64'(0));
    tick();
    req_valid = '0;
    check("oor_rsp_valid", 64'(rsp_valid), 64'(1));
    check("oor_flag", 64'(rsp_oor), 64'(1));
    check("oor_rsp_data", 64'(rsp_data), 64'(0));
    check("oor_rsp_id", 64'(rsp_id), 64'(2));
    host_rd = 1'b1; host_addr = 24'h123456;
    tick();
    host_rd = 1'b0;
    check("oor_rd_ack", 64'(host_ack), 64'(1));
    check("oor_rd_data", 64'(host_rdata), 64'(0));
    tick();
    host_wr = 1'b1; host_addr = 24'h000105; host_wdata = 32'hDEAD;
    #1;
    check("oor_wr_no_wren", 64'(tbl_host_wren), 64'(0));
    tick();
    host_wr = 1'b0;
    check("oor_wr_ack", 64'(host_ack), 64'(1));
    tick();
    host_rd = 1'b1; host_addr = 24'h05;
    tick();
    host_rd = 1'b0;
    check("oor_wr_dropped", 64'(host_rdata), 64'(32'hABC));

    // Sparse round-robin from pointer 2: 3, 1, 3.
    req_valid = 4'b1010; set_addr(1, 24'h07); set_addr(3, 24'h09);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("sp_ready", 64'(req_ready), 64'(rr_rdy[k]));
      tick();
      check("sp_rsp_id", 64'(rsp_id), 64'(rr_id[k]));
      check("sp_rsp_data", 64'(rsp_data), 64'(rr_dat[k]));
      check("sp_rsp_oor", 64'(rsp_oor), 64'(0));
    end
    req_valid = '0;
    tick();

    // Reset with a grant in flight and a host ack outstanding.
    req_valid = 4'b0001; set_addr(0, 24'h20);
    host_rd = 1'b1; host_addr = 24'h10;
    tick();
    check("mr_ack_before", 64'(host_ack), 64'(1));
    #1;
    check("mr_grant_before", 64'(req_ready), 64'(4'b0001));
    rst_n = 1'b0;
    #1;
    check("mr_ack_async", 64'(host_ack), 64'(0));
    tick();
    check("mr_rsp_valid", 64'(rsp_valid), 64'(0));
    check("mr_host_ack", 64'(host_ack), 64'(0));
    check("mr_req_ready", 64'(req_ready), 64'(0));
    check("mr_rsp_id", 64'(rsp_id), 64'(0));
    check("mr_rsp_data", 64'(rsp_data), 64'(0));
    check("mr_host_rdata", 64'(host_rdata), 64'(0));
    req_valid = '0; host_rd = 1'b0;
    rst_n = 1'b1;
    tick();
    check("mr_no_stale_rsp", 64'(rsp_valid), 64'(0));
    check("mr_no_stale_ack", 64'(host_ack), 64'(0));

    $display("Result: errors=%0d of %0d checks", error_cnt, check_cnt);
    $finish;
  end

endmodule
